axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter: DEPTH, 16, number of 32-bit memory words (power of two, 2..256).
REQ-002 Parameter: RESP_OKAY, 2'b00; RESP_SLVERR, 2'b10: response encodings.
REQ-003 aclk  in  1  sole clock; all logic rises on posedge aclk.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 araddr/arvalid/arlen/arsize/arburst  in  32/1/8/3/2  read address channel; arready  out  1.
REQ-006 rdata/rresp/rlast/rvalid  out  32/2/1/1  read data channel; rready  in  1.
REQ-007 awaddr/awvalid/awlen/awsize/awburst  in  32/1/8/3/2  write address channel; awready  out  1.
REQ-008 wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data channel; wready  out  1.
REQ-009 bresp/bvalid  out  2/1  write response channel; bready  in  1.

Function
REQ-010 FSM states SHALL be IDLE, RDATA, WDATA, WRESP; exactly one transaction outstanding.
REQ-011 In IDLE: arready=1; awready=1 only when arvalid=0 (read wins simultaneous requests; AW held, accepted next IDLE).
REQ-012 AR handshake (IDLE, arvalid) -> latch addr word index addr[log2(DEPTH)+1:2], beat count arlen, error flag; go RDATA next cycle.
REQ-013 AW handshake (IDLE, awvalid, !arvalid) -> latch same fields from AW; go WDATA next cycle.
REQ-014 Error flag set if addr >= 4*DEPTH, size != 3'b010, or burst != 2'b01 (INCR).
REQ-015 RDATA: rvalid=1; rdata=mem[ptr] (0 if error); rresp=SLVERR if error else OKAY; rlast=1 when beat index == arlen.
REQ-016 Read beat retires only on rvalid&rready; rdata/rresp/rlast SHALL stay stable while rready=0.
REQ-017 After retiring beat with rlast=1 -> IDLE next cycle; first rvalid one cycle after AR handshake.
REQ-018 WDATA: wready=1; each wvalid&wready beat writes mem[ptr] byte lanes where wstrb[i]=1, unless error flag set (write dropped).
REQ-019 Burst ends on beat index == awlen; wlast ignored for termination; wlast value mismatching final-beat position SHALL set error flag.
REQ-020 After final W beat -> WRESP; bvalid=1, bresp=SLVERR if error else OKAY; held until bready; then IDLE.
REQ-021 Pointer SHALL increment by one word per beat, wrapping modulo DEPTH (8-bit beat counter, 256 beats max).
REQ-022 Outside their states, arready/awready/rvalid/rlast/wready/bvalid SHALL be 0; rdata=0; rresp/bresp=0.
REQ-023 A read issued the cycle after a write's B handshake SHALL observe the written data.

Reset
REQ-024 areset=1 at posedge -> state IDLE, all counters/pointers/error flag 0, all mem words 0, outputs per REQ-022 next cycle.
REQ-025 Reset mid-burst SHALL abandon the transaction with no response; writes already retired stay then are cleared by REQ-024.
REQ-026 During reset arready and awready SHALL be 0.

Verification
REQ-027 AW addr 0x4 len 3, W data 0xDEADBEEF+i, wstrb 0xF, wlast on beat 3 -> mem[1..4]=0xDEADBEEF..0xDEADBEF2, bresp 00.
REQ-028 Then AR addr 0x4 len 3, rready=1 -> 4 beats 0xDEADBEEF..0xDEADBEF2, rlast on beat 4 only, rresp 00, first rvalid 1 cycle after AR.
REQ-029 arvalid and awvalid same cycle in IDLE -> AR accepted, awready=0; AW accepted on first IDLE cycle after read completes.
REQ-030 AW addr 0x3C len 1 data 0x11,0x22 -> mem[15]=0x11, mem[0]=0x22 (wrap); AR addr 0x40 len 0 -> rdata 0, rresp 10, rlast 1.
REQ-031 rready toggled 0/1 during 4-beat read -> each beat held stable while rready=0, no beat lost or duplicated.
REQ-032 areset pulsed after 2nd W beat -> IDLE, bvalid never asserted, following read of 0x4 returns 0.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a DEPTH x 32-bit memory. Only one
// transaction is in flight at a time. Reads win over simultaneous writes.
// Out-of-range addresses, non-32-bit sizes and non-INCR bursts complete
// with SLVERR: reads return zero data and writes are dropped.
//
// Ports:
//   aclk, areset                          clock, synchronous active-high reset
//   araddr/arvalid/arlen/arsize/arburst   read address channel, arready out
//   rdata/rresp/rlast/rvalid              read data channel, rready in
//   awaddr/awvalid/awlen/awsize/awburst   write address channel, awready out
//   wdata/wstrb/wlast/wvalid              write data channel, wready out
//   bresp/bvalid                          write response channel, bready in
module axi_slave_mem #(
  parameter int         DEPTH       = 16,
  parameter logic [1:0] RESP_OKAY   = 2'b00,
  parameter logic [1:0] RESP_SLVERR = 2'b10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;

  state_t        state_reg;
  logic [AW-1:0] ptr_reg;
  logic [7:0]    cnt_reg;
  logic [7:0]    len_reg;
  logic          err_reg;
  logic          rvalid_reg;
  logic          rlast_reg;
  logic [31:0]   rdata_reg;
  logic [1:0]    rresp_reg;
  logic          wready_reg;
  logic          bvalid_reg;
  logic [1:0]    bresp_reg;

  logic          ar_err;
  logic          aw_err;
  logic [AW-1:0] ar_idx;
  logic [AW-1:0] aw_idx;
  logic [AW-1:0] ptr_next;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_word;
  logic          w_final;
  logic          wlast_bad;
  logic          wr_en;

  assign ar_err = (araddr >= 32'(4 * DEPTH)) || (arsize != 3'b010) || (arburst != 2'b01);
  assign aw_err = (awaddr >= 32'(4 * DEPTH)) || (awsize != 3'b010) || (awburst != 2'b01);
  assign ar_idx = araddr[AW+1:2];
  assign aw_idx = awaddr[AW+1:2];
  assign ptr_next = ptr_reg + AW'(1);

  // Handshake readiness is gated by reset so nothing is accepted while
  // areset is high, even though the state register already reads IDLE.
  assign arready = (state_reg == IDLE) && !areset;
  assign awready = (state_reg == IDLE) && !areset && !arvalid;

  // In IDLE the memory is read at the incoming AR index so the first beat
  // is ready one cycle after the handshake; during a burst it prefetches
  // the next word so the following beat can be loaded on retirement.
  assign rd_addr = (state_reg == IDLE) ? ar_idx : ptr_next;

  assign w_final   = (cnt_reg == len_reg);
  assign wlast_bad = (wlast != w_final);
  assign wr_en     = wready_reg && wvalid && !err_reg;

  // Memory is split into four byte lanes so each strobe bit owns its own
  // storage and write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge aclk) begin
        if (areset) begin
          for (int i = 0; i < DEPTH; i++) begin
            lane_mem[i] <= 8'd0;
          end
        end else if (wr_en && wstrb[gi]) begin
          lane_mem[ptr_reg] <= wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[rd_addr];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= 8'd0;
      len_reg    <= 8'd0;
      err_reg    <= 1'b0;
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rdata_reg  <= 32'd0;
      rresp_reg  <= 2'b00;
      wready_reg <= 1'b0;
      bvalid_reg <= 1'b0;
      bresp_reg  <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arvalid) begin
            state_reg  <= RDATA;
            ptr_reg    <= ar_idx;
            cnt_reg    <= 8'd0;
            len_reg    <= arlen;
            err_reg    <= ar_err;
            rvalid_reg <= 1'b1;
            rdata_reg  <= ar_err ? 32'd0 : rd_word;
            rresp_reg  <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rlast_reg  <= (arlen == 8'd0);
          end else if (awvalid) begin
            state_reg  <= WDATA;
            ptr_reg    <= aw_idx;
            cnt_reg    <= 8'd0;
            len_reg    <= awlen;
            err_reg    <= aw_err;
            wready_reg <= 1'b1;
          end
        end
        RDATA: begin
          if (rready) begin
            if (rlast_reg) begin
              state_reg  <= IDLE;
              rvalid_reg <= 1'b0;
              rlast_reg  <= 1'b0;
              rdata_reg  <= 32'd0;
              rresp_reg  <= 2'b00;
            end else begin
              ptr_reg   <= ptr_next;
              cnt_reg   <= cnt_reg + 8'd1;
              rdata_reg <= err_reg ? 32'd0 : rd_word;
              rlast_reg <= ((cnt_reg + 8'd1) == len_reg);
            end
          end
        end
        WDATA: begin
          if (wvalid) begin
            // A misplaced wlast poisons the rest of the burst; the beat
            // count alone decides where the burst ends.
            if (wlast_bad) begin
              err_reg <= 1'b1;
            end
            if (w_final) begin
              state_reg  <= WRESP;
              wready_reg <= 1'b0;
              bvalid_reg <= 1'b1;
              bresp_reg  <= (err_reg || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              ptr_reg <= ptr_next;
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            state_reg  <= IDLE;
            bvalid_reg <= 1'b0;
            bresp_reg  <= 2'b00;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rvalid = rvalid_reg;
  assign rlast  = rlast_reg;
  assign rdata  = rdata_reg;
  assign rresp  = rresp_reg;
  assign wready = wready_reg;
  assign bvalid = bvalid_reg;
  assign bresp  = bresp_reg;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed bench for axi_slave_mem. A word-array memory
// model predicts every read beat and write response; a negedge monitor
// compares the DUT against those predictions on every cycle, and a few
// literal values pin the model to hand-computed results.
`timescale 1ns/1ps
module tb_axi_slave_mem;
  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] araddr;
  logic        arvalid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_slave_mem #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .araddr(araddr), .arvalid(arvalid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic [31:0] model_mem [DEPTH];
  rbeat_t      exp_r [$];
  logic [1:0]  exp_b [$];
  logic [31:0] got_data [$];
  logic [1:0]  got_resp [$];
  logic        got_last [$];

  int   w_idx;
  int   w_len;
  logic w_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  function automatic logic req_err(input logic [31:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (addr >= 32'(4 * DEPTH)) || (size != 3'b010) || (burst != 2'b01);
  endfunction

  // Monitor: every beat on offer must match the head of the prediction
  // queue (which also proves stability while rready is low); idle
  // channels must drive zeros.
  always @(negedge aclk) begin
    if (!areset) begin
      if (rvalid) begin
        check("busy_arready", 32'(arready), 32'd0);
        check("busy_awready", 32'(awready), 32'd0);
        if (exp_r.size() == 0) begin
          check("r_unexpected_rvalid", 32'(rvalid), 32'd0);
        end else begin
          check("rdata", rdata, exp_r[0].data);
          check("rresp", 32'(rresp), 32'(exp_r[0].resp));
          check("rlast", 32'(rlast), 32'(exp_r[0].last));
          if (rready) begin
            got_data.push_back(rdata);
            got_resp.push_back(rresp);
            got_last.push_back(rlast);
            void'(exp_r.pop_front());
          end
        end
      end else begin
        check("rdata_idle", rdata, 32'd0);
        check("rresp_rlast_idle", {29'd0, rresp, rlast}, 32'd0);
      end
      if (bvalid) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_bvalid", 32'(bvalid), 32'd0);
        end else begin
          check("bresp", 32'(bresp), 32'(exp_b[0]));
          if (bready) void'(exp_b.pop_front());
        end
      end else begin
        check("bresp_idle", 32'(bresp), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    areset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge aclk);
      check("reset_arready", 32'(arready), 32'd0);
      check("reset_awready", 32'(awready), 32'd0);
      tick();
    end
    areset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    exp_r.delete();
    exp_b.delete();
    @(negedge aclk);
    check("post_reset_arready", 32'(arready), 32'd1);
    check("post_reset_awready", 32'(awready), 32'd1);
    check("post_reset_valids", {29'd0, rvalid, wready, bvalid}, 32'd0);
    tick();
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic   hs;
    logic   e;
    int     idx;
    rbeat_t b;
    got_data.delete();
    got_resp.delete();
    got_last.delete();
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge aclk);
      hs = arready;
      if (hs && awvalid) check("ar_wins_awready", 32'(awready), 32'd0);
      tick();
    end
    arvalid = 1'b0;
    if (!hs) fail_now("ar_handshake");
    e = req_err(addr, size, burst);
    idx = int'(addr >> 2);
    for (int i = 0; i <= int'(len); i++) begin
      b.data = e ? 32'd0 : model_mem[(idx + i) % DEPTH];
      b.resp = e ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_r.push_back(b);
    end
    check("r_first_latency", 32'(rvalid), 32'd1);
  endtask

  task automatic r_phase(input int mode);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      rready = (mode == 0) ? 1'b1 : 1'(c % 2);
      @(negedge aclk);
      done = rvalid && rready && rlast;
      tick();
    end
    rready = 1'b0;
    if (!done) fail_now("r_last_beat");
    check("r_beats_left", 32'(exp_r.size()), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int mode);
    ar_phase(addr, len, 3'b010, 2'b01);
    r_phase(mode);
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output int waited);
    logic hs;
    awaddr = addr; awlen = len; awsize = 3'b010; awburst = burst; awvalid = 1'b1;
    hs = 1'b0;
    waited = 0;
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge aclk);
      hs = awready;
      tick();
      if (!hs) waited++;
    end
    awvalid = 1'b0;
    if (!hs) fail_now("aw_handshake");
    w_idx = int'(addr >> 2);
    w_len = int'(len);
    w_err = req_err(addr, 3'b010, burst);
  endtask

  // nbeats < 0 sends the whole burst; otherwise stop early (no response).
  task automatic w_phase(input logic [31:0] base, input logic [31:0] step,
                         input logic [3:0] strb, input logic bad_last, input int nbeats);
    logic hs;
    int   p;
    int   n;
    n = (nbeats < 0) ? w_len + 1 : nbeats;
    for (int i = 0; i < n; i++) begin
      wdata  = base + step * 32'(i);
      wstrb  = strb;
      wlast  = bad_last ? 1'b0 : (i == w_len);
      wvalid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 100 && !hs; c++) begin
        @(negedge aclk);
        hs = wready;
        tick();
      end
      if (!hs) fail_now("w_handshake");
      p = (w_idx + i) % DEPTH;
      if (!w_err) begin
        for (int k = 0; k < 4; k++) begin
          if (strb[k]) model_mem[p][8*k +: 8] = wdata[8*k +: 8];
        end
      end
      if (wlast != (i == w_len)) w_err = 1'b1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    if (n == w_len + 1) exp_b.push_back(w_err ? 2'b10 : 2'b00);
  endtask

  task automatic b_phase(input int delay);
    logic hs;
    bready = 1'b0;
    for (int c = 0; c < delay; c++) tick();
    bready = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge aclk);
      hs = bvalid;
      tick();
    end
    bready = 1'b0;
    if (!hs) fail_now("b_handshake");
    check("b_left", 32'(exp_b.size()), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] base, input logic [31:0] step,
                          input logic [3:0] strb, input logic bad_last);
    int waited;
    aw_phase(addr, len, burst, waited);
    w_phase(base, step, strb, bad_last, -1);
    b_phase(2);
  endtask

  initial begin
    int waited;
    areset = 1'b1;
    araddr = '0; arvalid = 1'b0; arlen = '0; arsize = '0; arburst = '0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    do_reset(3);

    // Memory is all zeros out of reset.
    do_read(32'h0, 8'd15, 0);
    check("reset_mem_word7", got_data[7], 32'd0);

    // Four-beat write then read-back.
    do_write(32'h4, 8'd3, 2'b01, 32'hDEADBEEF, 32'd1, 4'hF, 1'b0);
    do_read(32'h4, 8'd3, 0);
    check("rb_beat0", got_data[0], 32'hDEADBEEF);
    check("rb_beat3", got_data[3], 32'hDEADBEF2);
    check("rb_last0", 32'(got_last[0]), 32'd0);
    check("rb_last3", 32'(got_last[3]), 32'd1);

    // Simultaneous AR and AW: read first, AW taken on the first idle cycle.
    awaddr = 32'h3C; awlen = 8'd1; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    do_read(32'h8, 8'd1, 0);
    check("collide_rdata", got_data[1], 32'hDEADBEF1);
    aw_phase(32'h3C, 8'd1, 2'b01, waited);
    check("aw_after_read_wait", 32'(waited), 32'd0);
    w_phase(32'h11, 32'h11, 4'hF, 1'b0, -1);
    b_phase(0);

    // Wrap-around and out-of-range read.
    do_read(32'h3C, 8'd1, 0);
    check("wrap_beat0", got_data[0], 32'h11);
    check("wrap_beat1", got_data[1], 32'h22);
    do_read(32'h40, 8'd0, 0);
    check("oor_rdata", got_data[0], 32'd0);
    check("oor_rresp", 32'(got_resp[0]), 32'd2);
    check("oor_rlast", 32'(got_last[0]), 32'd1);

    // Back-pressured read.
    do_read(32'h4, 8'd3, 1);
    check("bp_count", 32'(got_data.size()), 32'd4);
    check("bp_beat1", got_data[1], 32'hDEADBEF0);

    // Bad size read, FIXED-burst write (dropped), partial strobe, bad wlast.
    ar_phase(32'h0, 8'd1, 3'b001, 2'b01);
    r_phase(0);
    check("bad_size_rresp", 32'(got_resp[1]), 32'd2);
    do_write(32'h8, 8'd0, 2'b00, 32'h12345678, 32'd0, 4'hF, 1'b0);
    do_read(32'h8, 8'd0, 0);
    check("fixed_dropped", got_data[0], 32'hDEADBEF0);
    do_write(32'h14, 8'd0, 2'b01, 32'hAABBCCDD, 32'd0, 4'b0101, 1'b0);
    do_read(32'h14, 8'd0, 0);
    check("strobe_merge", got_data[0], 32'h00BB00DD);
    do_write(32'h30, 8'd0, 2'b01, 32'h55, 32'd0, 4'hF, 1'b1);

    // Reset in the middle of a write burst.
    aw_phase(32'h4, 8'd3, 2'b01, waited);
    w_phase(32'hCAFE0000, 32'd1, 4'hF, 1'b0, 2);
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      check("no_bvalid_after_reset", 32'(bvalid), 32'd0);
      tick();
    end
    do_read(32'h4, 8'd0, 0);
    check("reset_cleared_write", got_data[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
